// File: rtl/rca_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller.
// This package holds the slice width, the controller state encoding and the index-width helper.
package rca_pkg;

  localparam int SLICE_W = 4;

  // Encoding 2'd3 is unused; the controller treats it as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rip_carry.sv
// 4-bit ripple-carry adder slice.
// It is shared by the sequencing controller across successive nibbles.
module rip_carry (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       co
);

  always_comb begin
    logic c;
    // NOTE: blocking assignments are deliberate here; each bit must read the carry the bit below just produced.
    c = cin;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/rca_seq_add_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit ripple slice reused over NIBBLES passes, LSB first.
// Operands are taken on a valid/ready request and the result is held until a valid/ready retire.
module rca_seq_add_ctrl
  import rca_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE_W*NIBBLES-1:0] in_a,
  input  logic [SLICE_W*NIBBLES-1:0] in_b,
  input  logic                       in_sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*NIBBLES-1:0] out_sum,
  output logic                       out_cout,
  output logic                       out_ovf,
  output logic                       busy
);

  localparam int WIDTH = SLICE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] a_nib, b_nib, s_nib;
  logic               co_nib;
  logic               last_pass;
  logic               accept;

  assign accept    = in_valid && in_ready;
  assign last_pass = (idx == IDX_W'(NIBBLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: state_nx defaults to state so no branch leaves it unassigned and infers a latch.
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last_pass) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_reg[i*SLICE_W +: SLICE_W];
        b_nib = b_reg[i*SLICE_W +: SLICE_W];
      end
    end
  end

  rip_carry u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry),
    .s   (s_nib),
    .co  (co_nib)
  );

  // NOTE: operand registers have no reset; they are always loaded on accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= in_a;
      b_reg <= in_sub ? ~in_b : in_b;
    end
  end

  // Subtraction arrives here as A + ~B with the initial carry set to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry    <= 1'b0;
      idx      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            carry <= in_sub;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) out_sum[i*SLICE_W +: SLICE_W] <= s_nib;
          end
          carry <= co_nib;
          idx   <= last_pass ? '0 : idx + 1'b1;
          if (last_pass) begin
            out_cout <= co_nib;
            out_ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (s_nib[SLICE_W-1] != a_reg[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rca_seq_add_ctrl.md
Name: rca_seq_add_ctrl

Overview:
Sequencing controller that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit ripple-carry adder slice over successive nibbles, LSB first, with a registered carry between passes. It sits between a requester (valid/ready operand interface) and a consumer (valid/ready result interface). This trades NIBBLES cycles of latency for a single 4-bit adder instance.

Parameters:
NIBBLES, 4, number of 4-bit passes; operand width WIDTH = 4*NIBBLES (min 1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand request
in_ready  out  1  controller can accept operands
in_a  in  4*NIBBLES  operand A (unsigned / two's complement)
in_b  in  4*NIBBLES  operand B
in_sub  in  1  0 = A+B, 1 = A-B
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_sum  out  4*NIBBLES  result
out_cout  out  1  carry out of MSB (for sub: 1 = no borrow, A>=B unsigned)
out_ovf  out  1  signed two's-complement overflow
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (synchronous, active-high; clk and rst as named): state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, carry reg=0, nibble index=0. Takes priority over all other events, including mid-RUN or mid-DONE. The in-flight operation is discarded with no result.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch A into a_reg.
  - latch B_eff = in_sub ? ~in_b : in_b into b_reg.
  - carry <= in_sub, idx <= 0.
  - go to RUN.
  - Operands are sampled only on the accepting edge.
- RUN: in_ready=0. Each cycle, slice inputs are a_reg[4*idx+:4], b_reg[4*idx+:4] and carry.
  - Write slice sum into out_sum[4*idx+:4]; carry <= slice co; idx <= idx+1.
  - When idx==NIBBLES-1: out_cout <= slice co; out_ovf <= (A[MSB]==B_eff[MSB]) && (sum[MSB]!=A[MSB]); go to DONE.
- DONE: out_valid=1. out_sum, out_cout and out_ovf stay stable until out_valid&&out_ready, then go to IDLE (out_valid=0 the next cycle).
  - in_ready=0 in DONE. There is no same-cycle accept-on-retire; the earliest new accept is the cycle after the result handshake.
- Latency: out_valid goes high after exactly NIBBLES clock edges following the accepting edge. Throughput is at most one operation per NIBBLES+2 cycles.
- out_sum contents are defined only while out_valid=1. Partial nibbles are visible during RUN but carry no meaning.
- Arithmetic is modulo 2^WIDTH; wrap-around is reported via out_cout and out_ovf only.
- in_valid while not in IDLE is ignored and has no side effects. out_ready outside DONE is ignored.
- NIBBLES=1 degenerates to a single RUN cycle; all rules above still hold.

Decomposition:
- Shared package rca_pkg holds:
  - SLICE_W=4.
  - 2-bit state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - The $clog2-based index-width helper.
- One sub-module: the team's existing 4-bit ripple-carry adder rip_carry (a, b, cin, s, co), instantiated once as the datapath slice.
- Controller FSM, operand/carry/index registers and result registers live in rca_seq_add_ctrl.

Test Plan:
- NIBBLES=4, add 16'h1234 + 16'h0FFF -> out_sum=16'h2233, cout=0, ovf=0; out_valid rises exactly 4 edges after accept.
- Add 16'hFFFF + 16'h0001 -> out_sum=16'h0000, cout=1, ovf=0 (carry ripples through all four passes). Add 16'h7FFF + 16'h0001 -> 16'h8000, cout=0, ovf=1.
- Sub 16'h0005 - 16'h0007 -> 16'hFFFE, cout=0, ovf=0. Sub 16'h8000 - 16'h0001 -> 16'h7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands.
  - Outputs stay bit-stable, in_ready stays 0 and new operands are not captured.
  - On out_ready=1, one handshake occurs, then IDLE with in_ready=1 the next cycle.
- Reset mid-operation: assert rst for one cycle after 2 RUN passes.
  - Next cycle: IDLE, in_ready=1, out_valid=0, out_sum=0, busy=0.
  - A following add 16'h0001+16'h0001 returns 16'h0002, cout=0, proving no stale carry or index.
- Exhaustive sweep with NIBBLES=1: all 16x16 A/B pairs for both in_sub values against a reference model, with random out_ready stalls -> zero mismatches, exactly one result per accepted request.
